// File: rtl/invert_pkg.sv
// Shared types and the reference response function for the 8-bit inverter checker.
package invert_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One stimulus/response vector pair as seen by the checker.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] f;
    } pair_t;

    // Expected inverter response; also used by the inverter model.
    function automatic logic [WIDTH-1:0] expected_f(input logic [WIDTH-1:0] a);
        return ~a;
    endfunction

endpackage

// File: rtl/invert_checker_if.sv
// Vector stream and result bus between the stimulus source (master) and the checker (slave).
interface invert_checker_if #(
    parameter int unsigned NUM_VECTORS = 32
) ();
    import invert_pkg::WIDTH;

    localparam int unsigned CNT_W = $clog2(NUM_VECTORS + 1);

    logic             START;
    logic             VALID;
    logic [WIDTH-1:0] A_IN;
    logic [WIDTH-1:0] F_IN;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [CNT_W-1:0] ERR_COUNT;
    logic             SEQ_ERR;
    logic [CNT_W-1:0] FIRST_ERR_IDX;
    logic [WIDTH-1:0] FIRST_ERR_A;
    logic [WIDTH-1:0] FIRST_ERR_F;

    modport master (
        output START, VALID, A_IN, F_IN,
        input  BUSY, DONE, PASS, ERR_COUNT, SEQ_ERR,
               FIRST_ERR_IDX, FIRST_ERR_A, FIRST_ERR_F
    );

    modport slave (
        input  START, VALID, A_IN, F_IN,
        output BUSY, DONE, PASS, ERR_COUNT, SEQ_ERR,
               FIRST_ERR_IDX, FIRST_ERR_A, FIRST_ERR_F
    );

endinterface

// File: rtl/invert_err_capture.sv
// Saturating data-mismatch counter and first-mismatch capture registers.
module invert_err_capture
    import invert_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             data_err,
    input  logic [CNT_W-1:0] idx,
    input  pair_t            pair,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_idx,
    output pair_t            first_pair
);

    // A zero count marks the first mismatch of the run; saturation never returns it to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count  <= '0;
            first_idx  <= '0;
            first_pair <= '0;
        end else if (accept && data_err) begin
            if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (err_count == '0) begin
                first_idx  <= idx;
                first_pair <= pair;
            end
        end
    end

endmodule

// File: rtl/invert_checker.sv
// Response checker for the 8-bit inverter: verifies F == ~A over an ascending A sweep.
// Optional INVERT_CHECKER_HALT_EN ends the run at the first data or sequence error.
module invert_checker
    import invert_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 32
) (
    input logic              CLK,
    input logic              RST,
    invert_checker_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(NUM_VECTORS + 1);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             pass;
    logic             seq_err;

    logic             accept;
    logic             clear;
    logic             data_err;
    logic             seq_now;
    logic             last;
    logic             finish;
    pair_t            pair;
    pair_t            first_pair;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_idx;

    assign pair     = '{a: bus.A_IN, f: bus.F_IN};
    assign accept   = (state == RUN) && bus.VALID;
    assign clear    = (state != RUN) && bus.START;
    assign data_err = bus.F_IN != expected_f(bus.A_IN);
    assign seq_now  = bus.A_IN != WIDTH'(idx);
    assign last     = idx == CNT_W'(NUM_VECTORS - 1);

`ifdef INVERT_CHECKER_HALT_EN
    assign finish = last || data_err || seq_now;
`else
    assign finish = last;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.START) begin
                        state   <= RUN;
                        idx     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        seq_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.VALID) begin
                        idx <= idx + CNT_W'(1);
                        if (seq_now) begin
                            seq_err <= 1'b1;
                        end
                        // PASS folds in the error status of the pair accepted on this edge.
                        if (finish) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !data_err && !seq_err && !seq_now;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    invert_err_capture #(
        .CNT_W (CNT_W)
    ) u_err_capture (
        .clk        (CLK),
        .rst        (RST),
        .clear      (clear),
        .accept     (accept),
        .data_err   (data_err),
        .idx        (idx),
        .pair       (pair),
        .err_count  (err_count),
        .first_idx  (first_idx),
        .first_pair (first_pair)
    );

    assign bus.BUSY          = busy;
    assign bus.DONE          = done;
    assign bus.PASS          = pass;
    assign bus.SEQ_ERR       = seq_err;
    assign bus.ERR_COUNT     = err_count;
    assign bus.FIRST_ERR_IDX = first_idx;
    assign bus.FIRST_ERR_A   = first_pair.a;
    assign bus.FIRST_ERR_F   = first_pair.f;

endmodule

// File: tb/tb_invert_checker.sv
// Self-checking bench for invert_checker: queue-based run model plus directed literal pins.
// Honours INVERT_CHECKER_HALT_EN when defined for both the model and the pinned values.
module tb_invert_checker;

    localparam int unsigned N  = 32;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int          SAT = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    invert_checker_if #(.NUM_VECTORS(N)) bus ();

    invert_checker #(.NUM_VECTORS(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Run model: phase 0 idle, 1 running, 2 finished; accepted pairs kept in order.
    int         phase    = 0;
    bit         model_ok = 1'b0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qf[$];

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            phase = 0;
            qa.delete();
            qf.delete();
            model_ok = 1'b1;
        end else if (bus.START && phase != 1) begin
            phase = 1;
            qa.delete();
            qf.delete();
        end else if (phase == 1 && bus.VALID) begin
`ifdef INVERT_CHECKER_HALT_EN
            if ((bus.F_IN !== ~bus.A_IN) || (bus.A_IN !== W'(qa.size()))) phase = 2;
`endif
            qa.push_back(bus.A_IN);
            qf.push_back(bus.F_IN);
            if (qa.size() == N) phase = 2;
        end
    end

    // Outputs derived from the accepted-pair history, compared every cycle.
    always @(negedge CLK) begin : compare
        int ecnt;
        int fi;
        bit seq;
        if (model_ok) begin
            ecnt = 0;
            fi   = -1;
            seq  = 1'b0;
            for (int i = 0; i < qa.size(); i++) begin
                if (qf[i] !== ~qa[i]) begin
                    ecnt++;
                    if (fi < 0) fi = i;
                end
                if (qa[i] !== W'(i)) seq = 1'b1;
            end
            chk("busy",      32'(bus.BUSY),    32'(phase == 1));
            chk("done",      32'(bus.DONE),    32'(phase == 2));
            chk("pass",      32'(bus.PASS),    32'(phase == 2 && ecnt == 0 && !seq));
            chk("err_count", 32'(bus.ERR_COUNT), 32'(ecnt > SAT ? SAT : ecnt));
            chk("seq_err",   32'(bus.SEQ_ERR), 32'(seq));
            chk("first_idx", 32'(bus.FIRST_ERR_IDX), 32'(fi < 0 ? 0 : fi));
            chk("first_a",   32'(bus.FIRST_ERR_A), 32'(fi < 0 ? 8'h00 : qa[fi]));
            chk("first_f",   32'(bus.FIRST_ERR_F), 32'(fi < 0 ? 8'h00 : qf[fi]));
        end
    end

    // Cycle of first DONE, counted with the START cycle as cycle 0.
    int start_c  = 0;
    int done_cyc = 0;
    bit done_seen = 1'b0;

    always @(negedge CLK) begin
        if (bus.DONE && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc - start_c + 1;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // mode 0 clean, 1 F=FF at 5, 2 faults at 3/10/20, 3 A skips 7.
    task automatic run_vectors(input int mode, input bit gap, input int abort_at);
        logic [W-1:0] a;
        logic [W-1:0] f;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        start_c   = cyc;
        done_seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            a = (mode == 3 && i >= 7) ? W'(i + 1) : W'(i);
            f = ~a;
            if (mode == 1 && i == 5) f = 8'hFF;
            if (mode == 2 && (i == 3 || i == 10 || i == 20)) f = ~a ^ 8'h10;
            bus.A_IN  = a;
            bus.F_IN  = f;
            bus.VALID = 1'b1;
            if (i == abort_at) begin
                RST = 1'b1;
                tick();
                bus.VALID = 1'b0;
                return;
            end
            tick();
            bus.VALID = 1'b0;
            if (gap) begin
                if (i == 10) bus.START = 1'b1;
                tick();
                bus.START = 1'b0;
            end
        end
        for (int k = 0; k < 8 && !done_seen; k++) tick();
        chk("done_timeout", 32'(done_seen), 32'd1);
    endtask

    initial begin
        bus.START = 1'b0;
        bus.VALID = 1'b0;
        bus.A_IN  = '0;
        bus.F_IN  = '0;
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_errs", 32'(bus.ERR_COUNT), 32'd0);
        RST = 1'b0;
        tick();

        run_vectors(0, 1'b0, -1);
        chk("clean_done_cyc", 32'(done_cyc), 32'd33);
        chk("clean_pass",     32'(bus.PASS), 32'd1);
        chk("clean_errs",     32'(bus.ERR_COUNT), 32'd0);
        chk("clean_seq",      32'(bus.SEQ_ERR), 32'd0);
        tick();

        run_vectors(1, 1'b0, -1);
        chk("single_errs",  32'(bus.ERR_COUNT), 32'd1);
        chk("single_idx",   32'(bus.FIRST_ERR_IDX), 32'd5);
        chk("single_a",     32'(bus.FIRST_ERR_A), 32'h05);
        chk("single_f",     32'(bus.FIRST_ERR_F), 32'hFF);
        chk("single_pass",  32'(bus.PASS), 32'd0);
`ifdef INVERT_CHECKER_HALT_EN
        chk("single_done_cyc", 32'(done_cyc), 32'd7);
`else
        chk("single_done_cyc", 32'(done_cyc), 32'd33);
`endif
        tick();

        run_vectors(2, 1'b0, -1);
`ifdef INVERT_CHECKER_HALT_EN
        chk("multi_errs", 32'(bus.ERR_COUNT), 32'd1);
`else
        chk("multi_errs", 32'(bus.ERR_COUNT), 32'd3);
`endif
        chk("multi_idx", 32'(bus.FIRST_ERR_IDX), 32'd3);
        chk("multi_a",   32'(bus.FIRST_ERR_A), 32'h03);
        chk("multi_f",   32'(bus.FIRST_ERR_F), 32'hEC);
        tick();

        run_vectors(3, 1'b0, -1);
        chk("seq_flag", 32'(bus.SEQ_ERR), 32'd1);
        chk("seq_errs", 32'(bus.ERR_COUNT), 32'd0);
        chk("seq_pass", 32'(bus.PASS), 32'd0);
`ifdef INVERT_CHECKER_HALT_EN
        chk("seq_done_cyc", 32'(done_cyc), 32'd9);
`endif
        tick();

        run_vectors(0, 1'b1, -1);
        chk("gap_done_cyc", 32'(done_cyc), 32'd64);
        chk("gap_pass",     32'(bus.PASS), 32'd1);
        chk("gap_errs",     32'(bus.ERR_COUNT), 32'd0);
        tick();

        run_vectors(0, 1'b0, 12);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        chk("abort_pass", 32'(bus.PASS), 32'd0);
        chk("abort_errs", 32'(bus.ERR_COUNT), 32'd0);
        RST = 1'b0;
        tick();

        run_vectors(0, 1'b0, -1);
        chk("restart_done_cyc", 32'(done_cyc), 32'd33);
        chk("restart_pass",     32'(bus.PASS), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
